// File: rtl/readout_pkg.sv
// Shared constants, FSM encoding and read-tag layout for the package readout path.
// Combinational definitions only; no latency, no flow control.
package readout_pkg;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 15;
    localparam int HALF_W     = 10;
    localparam int LEN_W      = HALF_W + 1;
    localparam int FIFO_DEPTH = 4;
    localparam int RD_LATENCY = 2;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    // One entry of the read-latency tag pipe: sel=1 picks odd_q.
    typedef struct packed {
        logic vld;
        logic sel;
        logic last;
    } tag_t;

endpackage

// File: rtl/package_readout_if.sv
// Output word stream of the package readout: data plus last flag, valid/ready.
// Transfer happens on valid & ready; the master holds data/last stable while stalled.
interface package_readout_if
    import readout_pkg::*;
#(
    parameter int WIDTH = DATA_W
) ();

    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/readout_fifo.sv
// Small synchronous FIFO with occupancy output and synchronous flush; head shows 0 when empty.
// Zero-latency head (write visible next cycle); pushes while full are ignored, the caller's credit prevents them.
module readout_fifo
    import readout_pkg::*;
#(
    parameter int WIDTH = DATA_W + 1,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic                     head_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push_vld && (count != (AW+1)'(DEPTH));
    assign do_pop    = pop_rdy && (count != '0);
    assign head_vld  = (count != '0);
    assign head_dat  = head_vld ? mem[rd_ptr] : '0;
    assign occupancy = count;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/package_readout.sv
// Reads completed packages back from the even/odd memories in word order onto a valid/ready stream.
// Issue-to-out_valid is 3 cycles; reads stop once 4 words are buffered or in flight, so backpressure never drops data.
module package_readout
    import readout_pkg::*;
#(
    parameter int DATA_W = readout_pkg::DATA_W,
    parameter int ADDR_W = readout_pkg::ADDR_W,
    parameter int PEND_W = 8
) (
    input  logic                 clk,
    input  logic                 live_rising,
    input  logic                 complete,
    input  logic [HALF_W-1:0]    HALF_PACKAGE_LENGTH,
    input  logic [ADDR_W-1:0]    MEMORY_DEPTH,
    output logic [ADDR_W-1:0]    even_rd_addr,
    output logic [ADDR_W-1:0]    odd_rd_addr,
    input  logic [DATA_W-1:0]    even_q,
    input  logic [DATA_W-1:0]    odd_q,
    package_readout_if.master    out_if,
    output logic [PEND_W-1:0]    pending,
    output logic                 overflow
);

    state_t                    state_q, state_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          idx_q, idx_d;
    logic [ADDR_W-1:0]         even_ptr_q, odd_ptr_q;
    tag_t                      tag_a_q, tag_b_q, tag_new;
    logic                      issue;
    logic                      issue_last;
    logic                      pend_dec;
    logic [$clog2(FIFO_DEPTH):0] occupancy;
    logic [3:0]                outstanding;
    logic                      head_vld;
    logic [DATA_W:0]           head_dat;
    logic [DATA_W:0]           push_dat;
    logic [ADDR_W-1:0]         depth_last;

    assign even_rd_addr = even_ptr_q;
    assign odd_rd_addr  = odd_ptr_q;
    assign depth_last   = MEMORY_DEPTH - ADDR_W'(1);

    // Words in the FIFO plus reads whose data has not yet landed.
    assign outstanding = 4'(occupancy) + 4'(tag_a_q.vld) + 4'(tag_b_q.vld);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        idx_d      = idx_q;
        issue      = 1'b0;
        issue_last = 1'b0;
        pend_dec   = 1'b0;
        tag_new    = '0;
        case (state_q)
            IDLE: begin
                if (pending != '0) begin
                    len_d = {HALF_PACKAGE_LENGTH, 1'b0};
                    idx_d = '0;
                    if (HALF_PACKAGE_LENGTH == '0) begin
                        pend_dec = 1'b1;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (outstanding < 4'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_q == len_q - LEN_W'(1)) begin
                        issue_last = 1'b1;
                        pend_dec   = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        tag_new = '{vld: issue, sel: idx_q[0], last: issue_last};
    end

    always_ff @(posedge clk) begin
        if (live_rising) begin
            state_q    <= IDLE;
            len_q      <= '0;
            idx_q      <= '0;
            even_ptr_q <= '0;
            odd_ptr_q  <= '0;
            tag_a_q    <= '0;
            tag_b_q    <= '0;
            pending    <= '0;
            overflow   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tag_a_q <= tag_new;
            tag_b_q <= tag_a_q;
            if (issue && !idx_q[0]) begin
                even_ptr_q <= (even_ptr_q < depth_last) ? even_ptr_q + ADDR_W'(1) : '0;
            end
            if (issue && idx_q[0]) begin
                odd_ptr_q <= (odd_ptr_q < depth_last) ? odd_ptr_q + ADDR_W'(1) : '0;
            end
            // A complete and a package retirement in the same cycle cancel out.
            if (complete && !pend_dec) begin
                if (&pending) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= pending + PEND_W'(1);
                end
            end else if (!complete && pend_dec) begin
                pending <= pending - PEND_W'(1);
            end
        end
    end

    assign push_dat = {tag_b_q.last, tag_b_q.sel ? odd_q : even_q};

    readout_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .flush     (live_rising),
        .push_vld  (tag_b_q.vld),
        .push_dat  (push_dat),
        .pop_rdy   (out_if.out_ready),
        .head_vld  (head_vld),
        .head_dat  (head_dat),
        .occupancy (occupancy)
    );

    assign out_if.out_valid = head_vld;
    assign out_if.out_data  = head_dat[DATA_W-1:0];
    assign out_if.out_last  = head_dat[DATA_W];

endmodule

// File: doc/package_readout.md
# package_readout

Downstream stage of the even/odd package writer. Counts `complete` pulses as pending packages and reads each package back from the even and odd memories in original word order (even word first, then odd, alternating). It presents the words on a valid/ready stream with a last-word flag. Its read pointers mirror the writer's address sequence, including wrap at `MEMORY_DEPTH`.

## Interface
- `DATA_W`, 16, memory/stream word width
- `ADDR_W`, 15, memory address width
- `PEND_W`, 8, pending-package counter width
- `clk`  in  1  system clock
- `live_rising`  in  1  synchronous active-high reset (same pulse that resets the writer)
- `complete`  in  1  one-cycle pulse per package fully written
- `HALF_PACKAGE_LENGTH`  in  10  words per memory per package; package length = 2×this
- `MEMORY_DEPTH`  in  ADDR_W  memory depth; pointers wrap to 0 after `MEMORY_DEPTH-1`
- `even_rd_addr`, `odd_rd_addr`  out  ADDR_W  memory read addresses
- `even_q`, `odd_q`  in  DATA_W  memory read data, fixed 2-cycle latency
- `out_data`  out  DATA_W  stream word
- `out_valid`  out  1  word available
- `out_ready`  in  1  consumer accepts; transfer when valid&ready
- `out_last`  out  1  marks final word of package
- `pending`  out  PEND_W  packages written but not fully issued
- `overflow`  out  1  sticky: `complete` arrived with `pending` at max

## Operation
- Reset (`live_rising`=1): `out_valid`/`out_last`/`overflow` 0, `out_data` 0, both addresses 0, `pending` 0, FSM IDLE, FIFO flushed, in-flight read tags discarded. This matches the writer's first address (0) after the same pulse.
- `pending`: +1 on `complete`; −1 on issue of a package's last word; both in the same cycle leave it unchanged. At all-ones, a further `complete` sets `overflow` and `pending` holds.
- FSM IDLE: if `pending`>0, latch `len={HALF_PACKAGE_LENGTH,1'b0}`, set `idx`=0, go to READ. If the latched `len` is 0, pop the package (`pending`−1) with no output and stay in IDLE.
- FSM READ: issue one read per cycle when credit allows (see below).
  - `idx` even: read `even_q` at `even_rd_addr`, then advance the even pointer.
  - `idx` odd: read `odd_q` at `odd_rd_addr`, then advance the odd pointer.
  - Pointer advance: `ptr<MEMORY_DEPTH-1 ? ptr+1 : 0`.
  - Issue with `idx==len-1` sets the tag `last`, decrements `pending`, and returns the FSM to IDLE.
- Credit: issue only if FIFO occupancy + in-flight reads < 4. The FIFO never overflows.
- A 2-stage tag pipe (valid, sel even/odd, last) tracks issues. At tag maturity, `{last, sel?odd_q:even_q}` is pushed into the 4-entry FIFO.
- FIFO head drives `out_data`/`out_last`, and `out_valid` = not empty. Pop on valid&ready.
- Inputs `HALF_PACKAGE_LENGTH`/`MEMORY_DEPTH` are sampled per package and per pointer advance. Changing them mid-package is unsupported.

## Timing
- Issue cycle I: address is on the port during cycle I. The matching `*_q` is valid in cycle I+2 and is pushed at the end of I+2. It is seen on `out_valid` in cycle I+3.
- `complete` in cycle 0 → `pending`=1 in cycle 1 → first issue in cycle 2 → first `out_valid` in cycle 5.
- With `out_ready` held high: one word per cycle inside a package, and one bubble cycle between back-to-back packages (IDLE visit).
- `out_ready` low: `out_data`, `out_last` and `out_valid` hold stable. Issue stops once 4 words are outstanding. Nothing is lost or duplicated.
- `live_rising` wins over every simultaneous event, including a `complete` in the same cycle, which is dropped.

## Structure
- Shared package/header `readout_pkg`: `DATA_W`, `ADDR_W`, `FIFO_DEPTH`=4, `RD_LATENCY`=2, FSM state encodings (IDLE, READ).
- One sub-module: `readout_fifo`, a synchronous FIFO of depth 4 and width DATA_W+1, with occupancy output and sync flush on `live_rising`.

## Test plan
- Basic order: HALF=2, DEPTH=16, even mem [A0,A1], odd mem [B0,B1], `complete`@0, ready=1 → A0,B0,A1,B1 in cycles 5–8; `out_last` only in cycle 8; `pending` back to 0.
- Wrap: DEPTH=5, HALF=3, two packages → second package even addresses 3,4,0 and odd addresses 3,4,0.
- Backpressure: ready=0 for 10 cycles mid-package → `out_valid`=1 with `out_data` frozen; at most 4 words outstanding; full sequence intact after release.
- Simultaneous events: `complete` in the same cycle as the last-word issue → `pending` unchanged; next package starts after one bubble.
- Reset mid-package: `live_rising` during READ → next cycle all outputs 0 and addresses 0; after a new `complete`, reads restart at address 0.
- Overflow: `PEND_W`=2, ready=0, HALF=512, 5 `complete` pulses → `pending`=3, `overflow`=1 and stays 1 until `live_rising`.
